// File: rtl/rvsteel_bus_arbiter_pkg.sv
// Shared bus widths, arbiter state encodings and helpers for rvsteel bus blocks.
package rvsteel_bus_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT0 = 2'd1;
  localparam logic [1:0] ST_WAIT1 = 2'd2;

  function automatic logic [1:0] owner_onehot(input logic [1:0] st);
    case (st)
      ST_WAIT0: owner_onehot = 2'b01;
      ST_WAIT1: owner_onehot = 2'b10;
      default:  owner_onehot = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/rvsteel_rr_arbiter_2.sv
// Combinational two-way grant picker: locked owner, else round-robin or fixed M0 priority.
module rvsteel_rr_arbiter_2
  import rvsteel_bus_arbiter_pkg::*;
#(
  parameter int unsigned ROUND_ROBIN = 1
) (
  input  logic [1:0] req,
  input  logic       last_winner,
  input  logic       lock,
  input  logic       lock_id,
  output logic       sel
);

  always_comb begin
    sel = 1'b0;
    if (lock) begin
      sel = lock_id;
    end else if (req == 2'b11) begin
      sel = (ROUND_ROBIN != 0) ? ~last_winner : 1'b0;
    end else begin
      sel = req[1];
    end
  end

endmodule

// File: rtl/rvsteel_bus_arbiter.sv
// Two-manager arbiter for one rvsteel memory-side bus port; zero-latency muxing,
// responses routed back only to the issuer of the in-flight request.
module rvsteel_bus_arbiter
  import rvsteel_bus_arbiter_pkg::*;
#(
  parameter int unsigned ROUND_ROBIN = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_rw_address,
  output logic [DATA_W-1:0] m0_read_data,
  input  logic              m0_read_request,
  output logic              m0_read_response,
  input  logic [DATA_W-1:0] m0_write_data,
  input  logic [STRB_W-1:0] m0_write_strobe,
  input  logic              m0_write_request,
  output logic              m0_write_response,
  input  logic [ADDR_W-1:0] m1_rw_address,
  output logic [DATA_W-1:0] m1_read_data,
  input  logic              m1_read_request,
  output logic              m1_read_response,
  input  logic [DATA_W-1:0] m1_write_data,
  input  logic [STRB_W-1:0] m1_write_strobe,
  input  logic              m1_write_request,
  output logic              m1_write_response,
  output logic [ADDR_W-1:0] s_rw_address,
  output logic [DATA_W-1:0] s_write_data,
  output logic [STRB_W-1:0] s_write_strobe,
  output logic              s_read_request,
  output logic              s_write_request,
  input  logic [DATA_W-1:0] s_read_data,
  input  logic              s_read_response,
  input  logic              s_write_response,
  output logic [1:0]        bus_owner
);

  logic [1:0] state_q, state_d;
  logic       last_winner_q, last_winner_d;
  logic [1:0] req;
  logic       done;
  logic       lock;
  logic       lock_id;
  logic       sel;
  logic       sel_req;

  assign req     = {m1_read_request | m1_write_request, m0_read_request | m0_write_request};
  assign done    = s_read_response | s_write_response;
  assign lock    = (state_q != ST_IDLE) && !done;
  assign lock_id = (state_q == ST_WAIT1);

  rvsteel_rr_arbiter_2 #(
    .ROUND_ROBIN(ROUND_ROBIN)
  ) u_pick (
    .req        (req),
    .last_winner(last_winner_q),
    .lock       (lock),
    .lock_id    (lock_id),
    .sel        (sel)
  );

  // Gating with reset keeps the subordinate quiet while reset is held low,
  // even though the grant path itself is purely combinational.
  assign sel_req = req[sel] && reset;

  always_comb begin
    s_rw_address    = '0;
    s_write_data    = '0;
    s_write_strobe  = '0;
    s_read_request  = 1'b0;
    s_write_request = 1'b0;
    if (sel_req) begin
      if (sel) begin
        s_rw_address    = m1_rw_address;
        s_write_data    = m1_write_data;
        s_write_strobe  = m1_write_strobe;
        s_read_request  = m1_read_request;
        s_write_request = m1_write_request;
      end else begin
        s_rw_address    = m0_rw_address;
        s_write_data    = m0_write_data;
        s_write_strobe  = m0_write_strobe;
        s_read_request  = m0_read_request;
        s_write_request = m0_write_request;
      end
    end
  end

  // A locked owner that dropped its request leaves sel_req low, which abandons to IDLE.
  always_comb begin
    state_d       = ST_IDLE;
    last_winner_d = last_winner_q;
    if (sel_req) begin
      state_d       = sel ? ST_WAIT1 : ST_WAIT0;
      last_winner_d = sel;
    end
  end

  always_comb begin
    m0_read_response  = (state_q == ST_WAIT0) && s_read_response;
    m0_write_response = (state_q == ST_WAIT0) && s_write_response;
    m1_read_response  = (state_q == ST_WAIT1) && s_read_response;
    m1_write_response = (state_q == ST_WAIT1) && s_write_response;
    m0_read_data      = (state_q == ST_WAIT0) ? s_read_data : '0;
    m1_read_data      = (state_q == ST_WAIT1) ? s_read_data : '0;
    bus_owner         = owner_onehot(state_q);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      last_winner_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      last_winner_q <= last_winner_d;
    end
  end

endmodule

// File: tb/tb_rvsteel_bus_arbiter.sv
// Directed and random checks of rvsteel_bus_arbiter against a transaction-level model.
module tb_rvsteel_bus_arbiter;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } txn_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [31:0] m0_rw_address, m0_write_data, m1_rw_address, m1_write_data;
  logic [3:0]  m0_write_strobe, m1_write_strobe;
  logic        m0_read_request, m0_write_request, m1_read_request, m1_write_request;
  logic [31:0] s_read_data;
  logic        s_read_response, s_write_response;

  // index 0: round-robin instance, index 1: fixed-priority instance
  logic [31:0] o_m0_rd [2];
  logic [31:0] o_m1_rd [2];
  logic [31:0] o_addr  [2];
  logic [31:0] o_wdata [2];
  logic [3:0]  o_strb  [2];
  logic        o_m0_rr [2];
  logic        o_m0_wr [2];
  logic        o_m1_rr [2];
  logic        o_m1_wr [2];
  logic        o_s_rr  [2];
  logic        o_s_wr  [2];
  logic [1:0]  o_owner [2];
  logic        use_fp = 1'b0;

  rvsteel_bus_arbiter #(.ROUND_ROBIN(1)) dut_rr (
    .clock(clock), .reset(reset),
    .m0_rw_address(m0_rw_address), .m0_read_data(o_m0_rd[0]), .m0_read_request(m0_read_request),
    .m0_read_response(o_m0_rr[0]), .m0_write_data(m0_write_data), .m0_write_strobe(m0_write_strobe),
    .m0_write_request(m0_write_request), .m0_write_response(o_m0_wr[0]),
    .m1_rw_address(m1_rw_address), .m1_read_data(o_m1_rd[0]), .m1_read_request(m1_read_request),
    .m1_read_response(o_m1_rr[0]), .m1_write_data(m1_write_data), .m1_write_strobe(m1_write_strobe),
    .m1_write_request(m1_write_request), .m1_write_response(o_m1_wr[0]),
    .s_rw_address(o_addr[0]), .s_write_data(o_wdata[0]), .s_write_strobe(o_strb[0]),
    .s_read_request(o_s_rr[0]), .s_write_request(o_s_wr[0]), .s_read_data(s_read_data),
    .s_read_response(s_read_response), .s_write_response(s_write_response), .bus_owner(o_owner[0])
  );

  rvsteel_bus_arbiter #(.ROUND_ROBIN(0)) dut_fp (
    .clock(clock), .reset(reset),
    .m0_rw_address(m0_rw_address), .m0_read_data(o_m0_rd[1]), .m0_read_request(m0_read_request),
    .m0_read_response(o_m0_rr[1]), .m0_write_data(m0_write_data), .m0_write_strobe(m0_write_strobe),
    .m0_write_request(m0_write_request), .m0_write_response(o_m0_wr[1]),
    .m1_rw_address(m1_rw_address), .m1_read_data(o_m1_rd[1]), .m1_read_request(m1_read_request),
    .m1_read_response(o_m1_rr[1]), .m1_write_data(m1_write_data), .m1_write_strobe(m1_write_strobe),
    .m1_write_request(m1_write_request), .m1_write_response(o_m1_wr[1]),
    .s_rw_address(o_addr[1]), .s_write_data(o_wdata[1]), .s_write_strobe(o_strb[1]),
    .s_read_request(o_s_rr[1]), .s_write_request(o_s_wr[1]), .s_read_data(s_read_data),
    .s_read_response(s_read_response), .s_write_response(s_write_response), .bus_owner(o_owner[1])
  );

  wire [31:0] m0_read_data      = o_m0_rd[use_fp];
  wire [31:0] m1_read_data      = o_m1_rd[use_fp];
  wire [31:0] s_rw_address      = o_addr[use_fp];
  wire [31:0] s_write_data      = o_wdata[use_fp];
  wire [3:0]  s_write_strobe    = o_strb[use_fp];
  wire        m0_read_response  = o_m0_rr[use_fp];
  wire        m0_write_response = o_m0_wr[use_fp];
  wire        m1_read_response  = o_m1_rr[use_fp];
  wire        m1_write_response = o_m1_wr[use_fp];
  wire        s_read_request    = o_s_rr[use_fp];
  wire        s_write_request   = o_s_wr[use_fp];
  wire [1:0]  bus_owner         = o_owner[use_fp];

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- subordinate: RAM with optional stall / stray response ----------------
  logic [31:0] mem     [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  int unsigned hold = 0;
  bit rand_stall = 0;
  bit stray = 0;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : dflt(a);
  endfunction
  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] st);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      s_read_response  <= 1'b0;
      s_write_response <= 1'b0;
      s_read_data      <= '0;
    end else if ((s_read_request || s_write_request) &&
                 !(hold > 0 || (rand_stall && $urandom_range(0, 99) < 30))) begin
      s_read_response  <= s_read_request;
      s_write_response <= s_write_request;
      s_read_data      <= s_read_request ? mem_rd(s_rw_address) : $urandom();
      if (s_write_request) mem[s_rw_address] = merge(mem_rd(s_rw_address), s_write_data, s_write_strobe);
    end else begin
      if (hold > 0 && (s_read_request || s_write_request)) hold = hold - 1;
      s_read_response  <= stray;
      s_write_response <= 1'b0;
      s_read_data      <= $urandom();
      stray = 0;
    end
  end

  // ---------------- managers and reference model ----------------
  txn_t        q0[$], q1[$];
  txn_t        cur[2];
  bit          busy[2];
  int unsigned age[2];
  int unsigned comp[2];
  int unsigned others[2];
  int          order[$];
  bit          rand_mgr = 0;
  int          owner = 0;   // 0 none, 1 M0, 2 M1 holding the in-flight request
  int          pref  = 1;   // manager that wins the next contended grant

  task automatic drive_pins();
    m0_read_request  = busy[0] && !cur[0].wr;
    m0_write_request = busy[0] && cur[0].wr;
    m0_rw_address    = busy[0] ? cur[0].addr : $urandom();
    m0_write_data    = busy[0] ? cur[0].data : $urandom();
    m0_write_strobe  = busy[0] ? cur[0].strb : 4'($urandom());
    m1_read_request  = busy[1] && !cur[1].wr;
    m1_write_request = busy[1] && cur[1].wr;
    m1_rw_address    = busy[1] ? cur[1].addr : $urandom();
    m1_write_data    = busy[1] ? cur[1].data : $urandom();
    m1_write_strobe  = busy[1] ? cur[1].strb : 4'($urandom());
  endtask

  task automatic drive_mgrs();
    for (int i = 0; i < 2; i++) begin
      if (!busy[i]) begin
        if (i == 0 && q0.size() > 0) begin
          cur[0] = q0.pop_front(); busy[0] = 1; age[0] = 0; others[0] = 0;
        end else if (i == 1 && q1.size() > 0) begin
          cur[1] = q1.pop_front(); busy[1] = 1; age[1] = 0; others[1] = 0;
        end else if (rand_mgr && $urandom_range(0, 1) == 1) begin
          cur[i].wr   = ($urandom_range(0, 1) == 1);
          cur[i].addr = 32'($urandom_range(0, 255)) << 2;
          cur[i].data = $urandom();
          cur[i].strb = 4'($urandom_range(1, 15));
          busy[i] = 1; age[i] = 0; others[i] = 0;
        end
      end else begin
        age[i]++;
        chk($sformatf("m%0d_wait_bound", i), age[i] > 300, 1'b0);
        if (age[i] > 300) busy[i] = 0;
      end
    end
    drive_pins();
  endtask

  task automatic check_responses();
    logic rr, wr, mine;
    logic [31:0] rd;
    chk("bus_owner", bus_owner, (owner == 1) ? 2'b01 : (owner == 2) ? 2'b10 : 2'b00);
    for (int i = 0; i < 2; i++) begin
      rr   = (i == 0) ? m0_read_response  : m1_read_response;
      wr   = (i == 0) ? m0_write_response : m1_write_response;
      rd   = (i == 0) ? m0_read_data      : m1_read_data;
      mine = (owner == i + 1);
      chk($sformatf("m%0d_resp", i), {rr, wr}, {mine && s_read_response, mine && s_write_response});
      chk($sformatf("m%0d_read_data", i), rd, mine ? s_read_data : 32'h0);
      if (rr || wr) begin
        order.push_back(i);
        comp[i]++;
        chk($sformatf("m%0d_issuer_busy", i), busy[i], 1'b1);
        if (busy[i]) begin
          chk($sformatf("m%0d_resp_kind", i), {rr, wr}, {!cur[i].wr, cur[i].wr});
          if (cur[i].wr) ref_mem[cur[i].addr] = merge(ref_rd(cur[i].addr), cur[i].data, cur[i].strb);
          else chk($sformatf("m%0d_read_value", i), rd, ref_rd(cur[i].addr));
          if (!use_fp) chk($sformatf("m%0d_rr_wait", i), others[i] > 1, 1'b0);
          if (busy[1-i]) others[1-i]++;
          busy[i] = 0;
        end
      end
    end
  endtask

  task automatic check_grant();
    bit r0, r1, done;
    int g;
    logic [69:0] exp;
    r0   = m0_read_request | m0_write_request;
    r1   = m1_read_request | m1_write_request;
    done = s_read_response | s_write_response;
    if (owner != 0 && !done) g = ((owner == 1) ? r0 : r1) ? owner : 0;
    else if (r0 && r1)       g = use_fp ? 1 : pref;
    else                     g = r0 ? 1 : (r1 ? 2 : 0);
    if (g != 0) pref = (g == 1) ? 2 : 1;
    if (g == 1)      exp = {m0_rw_address, m0_write_data, m0_write_strobe, m0_read_request, m0_write_request};
    else if (g == 2) exp = {m1_rw_address, m1_write_data, m1_write_strobe, m1_read_request, m1_write_request};
    else             exp = '0;
    chk("s_bus", {s_rw_address, s_write_data, s_write_strobe, s_read_request, s_write_request}, exp);
    owner = g;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    check_responses();
    drive_mgrs();
    #1;
    check_grant();
  endtask

  task automatic apply_reset(input logic fp);
    hold = 0; rand_stall = 0; rand_mgr = 0; stray = 0;
    q0.delete(); q1.delete(); order.delete();
    busy[0] = 0; busy[1] = 0; comp[0] = 0; comp[1] = 0;
    use_fp = fp;
    m0_read_request = 1'b1; m0_rw_address = 32'h40;
    m1_write_request = 1'b1; m1_rw_address = 32'h80;
    reset = 1'b0;
    #1;
    chk("reset_quiet_now", {m0_read_response, m0_write_response, m1_read_response, m1_write_response,
                            s_read_request, s_write_request, bus_owner, m0_read_data, m1_read_data}, '0);
    repeat (2) @(posedge clock);
    #1;
    chk("reset_quiet_held", {m0_read_response, m0_write_response, m1_read_response, m1_write_response,
                             s_read_request, s_write_request, bus_owner, m0_read_data, m1_read_data}, '0);
    drive_pins();
    owner = 0; pref = 1;
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    int exp_rr[4];
    int exp_fp[4];
    exp_rr = '{0, 1, 0, 1};
    exp_fp = '{0, 0, 1, 1};
    mem[32'h1000]     = 32'h1234_5678;
    ref_mem[32'h1000] = 32'h1234_5678;
    #1;
    apply_reset(1'b0);

    // M0 alone: back-to-back reads, one completion per cycle
    q0.push_back('{0, 32'h0, 32'h0, 4'h0});
    q0.push_back('{0, 32'h4, 32'h0, 4'h0});
    q0.push_back('{0, 32'h8, 32'h0, 4'h0});
    repeat (4) step();
    chk("b2b_m0_count", comp[0], 3);
    chk("b2b_m1_count", comp[1], 0);

    // stray subordinate response while idle must be dropped
    stray = 1;
    repeat (3) step();
    chk("stray_dropped", comp[0] + comp[1], 3);

    // contention, round-robin then fixed priority
    for (int m = 0; m < 2; m++) begin
      apply_reset(m == 1);
      q0.push_back('{0, 32'h10, 32'h0, 4'h0});
      q0.push_back('{0, 32'h14, 32'h0, 4'h0});
      q1.push_back('{0, 32'h20, 32'h0, 4'h0});
      q1.push_back('{0, 32'h24, 32'h0, 4'h0});
      for (int k = 0; k < 20 && order.size() < 4; k++) step();
      chk($sformatf("contend%0d_count", m), order.size(), 4);
      for (int k = 0; k < 4 && k < order.size(); k++)
        chk($sformatf("contend%0d_order%0d", m, k), order[k], (m == 0) ? exp_rr[k] : exp_fp[k]);
    end

    // M1 write held by subordinate stall while M0 waits
    apply_reset(1'b0);
    hold = 3;
    q1.push_back('{1, 32'h1000, 32'hCAFE_F00D, 4'b0011});
    step();
    q0.push_back('{0, 32'h1004, 32'h0, 4'h0});
    for (int k = 0; k < 10; k++) begin
      step();
      if (comp[1] != 0) break;
      chk("hold_owner", bus_owner, 2'b10);
      chk("hold_s_bus", {s_rw_address, s_write_data, s_write_strobe, s_write_request},
          {32'h1000, 32'hCAFE_F00D, 4'b0011, 1'b1});
    end
    chk("hold_m1_done", comp[1], 1);
    chk("hold_ram_word", mem_rd(32'h1000), 32'h1234_F00D);
    step();
    chk("hold_then_m0", bus_owner, 2'b01);

    // asynchronous reset in the middle of a pending M0 read
    apply_reset(1'b0);
    hold = 4;
    q0.push_back('{0, 32'h40, 32'h0, 4'h0});
    step();
    step();
    chk("midwait_owner", bus_owner, 2'b01);
    apply_reset(1'b0);
    q1.push_back('{0, 32'h50, 32'h0, 4'h0});
    q0.push_back('{0, 32'h44, 32'h0, 4'h0});
    for (int k = 0; k < 10 && order.size() < 1; k++) step();
    chk("post_reset_count", order.size() > 0, 1'b1);
    if (order.size() > 0) chk("post_reset_first", order[0], 0);

    // random soak: round-robin then fixed priority
    for (int m = 0; m < 2; m++) begin
      apply_reset(m == 1);
      rand_mgr = 1;
      rand_stall = 1;
      repeat ((m == 0) ? 7000 : 2500) step();
      rand_mgr = 0;
      for (int k = 0; k < 500 && (busy[0] || busy[1]); k++) step();
      chk($sformatf("soak%0d_drained", m), {busy[0], busy[1]}, 2'b00);
      chk($sformatf("soak%0d_active", m), (comp[0] > 100) && (comp[1] > 100), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
